vedic_mul_seq: RTL

- Multi-cycle RV32 M-extension multiply sequencer for MUL, MULH, MULHSU and MULHU.
- Time-shares one 32x4 row datapath built from 8 vedic4bmul tiles. It processes one 4-bit nibble of the multiplier per cycle and accumulates a 64-bit product.
- Sits beside the ALU in the execute stage, with a valid/ready request and response handshake and a flush kill.

---
 rtl/rv32_pkg.sv | 33 +++
 rtl/vedic_mul_seq_if.sv | 31 +++
 rtl/vedic4bmul.sv | 23 ++
 rtl/vedic_row32x4.sv | 38 +++
 rtl/vedic_mul_seq.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 M-extension multiply sequencer.
package rv32_pkg;

    // RV32M multiply flavours handled by the sequencer.
    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } mul_seq_state_e;

    // Multiplier bits consumed per CALC cycle.
    localparam int MUL_NIB_W = 4;

    // 2x2 vertically-and-crosswise product: the leaf of the vedic tile.
    function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
        logic v0, c0, c1, carry, v1;
        v0    = a[0] & b[0];
        c0    = a[1] & b[0];
        c1    = a[0] & b[1];
        carry = c0 & c1;
        v1    = a[1] & b[1];
        return {v1 & carry, v1 ^ carry, c0 ^ c1, v0};
    endfunction

endpackage

// File: rtl/vedic_mul_seq_if.sv
// Request/response bundle between the execute stage and the multiply sequencer.
interface vedic_mul_seq_if
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic            req_valid;
    logic            req_ready;
    mul_op_e         req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            kill;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            busy;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output req_valid, req_op, req_a, req_b, kill, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, busy
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, kill, rsp_ready,
        output req_ready, rsp_valid, rsp_result, busy
    );

endinterface

// File: rtl/vedic4bmul.sv
// 4x4 unsigned vedic multiplier tile built from four 2x2 crosswise products.
module vedic4bmul
    import rv32_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    logic [3:0] p_ll, p_hl, p_lh, p_hh;

    assign p_ll = vedic2x2(a_i[1:0], b_i[1:0]);
    assign p_hl = vedic2x2(a_i[3:2], b_i[1:0]);
    assign p_lh = vedic2x2(a_i[1:0], b_i[3:2]);
    assign p_hh = vedic2x2(a_i[3:2], b_i[3:2]);

    // Vertical terms at weight 0 and 4, crosswise terms at weight 2.
    assign p_o = {4'b0000, p_ll}
               + {2'b00, p_hl, 2'b00}
               + {2'b00, p_lh, 2'b00}
               + {p_hh, 4'b0000};

endmodule

// File: rtl/vedic_row32x4.sv
// One row of the multiplier array: XLEN-bit operand times a 4-bit nibble,
// built from XLEN/4 vedic tiles whose partial products are aligned and summed.
module vedic_row32x4
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           a_i,
    input  logic [MUL_NIB_W-1:0]      nib_i,
    output logic [XLEN+MUL_NIB_W-1:0] row_o
);

    localparam int NIB   = XLEN / MUL_NIB_W;
    localparam int ROW_W = XLEN + MUL_NIB_W;

    logic [2*MUL_NIB_W-1:0] tile_p [NIB];
    logic [ROW_W-1:0]       row_sum;

    for (genvar i = 0; i < NIB; i++) begin : g_tile
        vedic4bmul u_tile (
            .a_i (a_i[i*MUL_NIB_W +: MUL_NIB_W]),
            .b_i (nib_i),
            .p_o (tile_p[i])
        );
    end

    // Sum the tile products, each shifted to its operand nibble position.
    always_comb begin
        // NOTE: assign a default before the loop so no path leaves the sum unassigned (no latch).
        row_sum = '0;
        for (int i = 0; i < NIB; i++) begin
            row_sum = row_sum + (ROW_W'(tile_p[i]) << (MUL_NIB_W * i));
        end
    end

    assign row_o = row_sum;

endmodule

// File: rtl/vedic_mul_seq.sv
// Multi-cycle RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU).
// Works on magnitudes, one multiplier nibble per CALC cycle, then applies the
// sign in FIX. Optional macro VEDIC_MUL_SEQ_EARLY_EXIT_EN leaves CALC as soon
// as the remaining multiplier nibbles are zero; results are identical.
module vedic_mul_seq
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    vedic_mul_seq_if.slave        bus
);

    localparam int NIB   = XLEN / MUL_NIB_W;
    localparam int ACC_W = 2 * XLEN;
    localparam int ROW_W = XLEN + MUL_NIB_W;
    localparam int CNT_W = $clog2(NIB + 1);
    localparam int IDX_W = $clog2(XLEN);

    mul_seq_state_e   state_q, state_d;
    mul_op_e          op_q, op_d;
    logic [XLEN-1:0]  a_abs_q, a_abs_d;
    logic [XLEN-1:0]  b_abs_q, b_abs_d;
    logic             neg_q, neg_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic                 sign_a, sign_b;
    logic [IDX_W-1:0]     nib_base;
    logic [MUL_NIB_W-1:0] nib;
    logic [ROW_W-1:0]     row;
    logic [ACC_W-1:0]     row_shifted;
    logic [ACC_W-1:0]     acc_fixed;
    logic                 last_nib;

    assign sign_a = bus.req_a[XLEN-1] && (bus.req_op == OP_MULH || bus.req_op == OP_MULHSU);
    assign sign_b = bus.req_b[XLEN-1] && (bus.req_op == OP_MULH);

    assign nib_base = IDX_W'({cnt_q, 2'b00});
    assign nib      = b_abs_q[nib_base +: MUL_NIB_W];

    vedic_row32x4 #(.XLEN(XLEN)) u_row (
        .a_i   (a_abs_q),
        .nib_i (nib),
        .row_o (row)
    );

    assign row_shifted = ACC_W'(row) << {cnt_q, 2'b00};
    assign acc_fixed   = neg_q ? -acc_q : acc_q;

`ifdef VEDIC_MUL_SEQ_EARLY_EXIT_EN
    // Stop once every multiplier nibble above the current one is zero.
    assign last_nib = (cnt_q == CNT_W'(NIB - 1))
                   || ((b_abs_q >> {cnt_q + CNT_W'(1), 2'b00}) == '0);
`else
    assign last_nib = (cnt_q == CNT_W'(NIB - 1));
`endif

    // Next-state and datapath updates; kill overrides every state.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_abs_d  = a_abs_q;
        b_abs_d  = b_abs_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (bus.kill) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_d    = bus.req_op;
                        a_abs_d = sign_a ? -bus.req_a : bus.req_a;
                        b_abs_d = sign_b ? -bus.req_b : bus.req_b;
                        neg_d   = sign_a ^ sign_b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_d = acc_q + row_shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_nib) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    acc_d    = acc_fixed;
                    result_d = (op_q == OP_MUL) ? acc_fixed[XLEN-1:0] : acc_fixed[ACC_W-1:XLEN];
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            a_abs_q  <= '0;
            b_abs_q  <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            a_abs_q  <= a_abs_d;
            b_abs_q  <= b_abs_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.rsp_valid  = (state_q == ST_DONE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.rsp_result = result_q;

endmodule
